// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states and keyboard commands.
// Imported by the host transmitter and the keyboard receive path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data pins, plus a
// registered falling-edge strobe on the synchronized clock.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic data,
  output logic clk_s,
  output logic data_s,
  output logic fe
);

  logic [2:0] csr;
  logic [1:0] dsr;

  // csr[2] is the edge register; the lines idle high.
  always_ff @(posedge clk) begin
    if (reset) begin
      csr <= 3'b111;
      dsr <= 2'b11;
      fe  <= 1'b0;
    end else begin
      csr <= {csr[1:0], ps2_clk};
      dsr <= {dsr[0], data};
      fe  <= csr[2] & ~csr[1];
    end
  end

  assign clk_s  = csr[1];
  assign data_s = dsr[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain pin enables.
// Define PS2_HOST_TX_ACK_CHECK_EN to report a missing device ACK as error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       ps2_clk,
  input  logic       data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state, state_n;
  logic [8:0]    shreg, shreg_n;
  logic [2:0]    bcnt, bcnt_n;
  logic [IW-1:0] icnt, icnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          drv, drv_n;
  logic          done_n, error_n;
  logic          clk_s, dat_s, fe;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
  logic          ack, ack_n;
`endif

  ps2_sync_edge u_sync (
    .clk    (clk),
    .reset  (reset),
    .ps2_clk(ps2_clk),
    .data   (data),
    .clk_s  (clk_s),
    .data_s (dat_s),
    .fe     (fe)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      bcnt  <= '0;
      icnt  <= '0;
      tcnt  <= '0;
      drv   <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
      ack   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      bcnt  <= bcnt_n;
      icnt  <= icnt_n;
      tcnt  <= tcnt_n;
      drv   <= drv_n;
      done  <= done_n;
      error <= error_n;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
      ack   <= ack_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bcnt_n  = bcnt;
    icnt_n  = icnt;
    tcnt_n  = tcnt;
    drv_n   = drv;
    done_n  = 1'b0;
    error_n = 1'b0;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
    ack_n   = ack;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          shreg_n = {~^tx_byte, tx_byte};
          icnt_n  = '0;
          bcnt_n  = '0;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
          drv_n   = 1'b1;
          state_n = REQ;
        end else begin
          icnt_n = icnt + 1'b1;
        end
      end
      REQ: begin
        if (fe) begin
          drv_n   = ~shreg[0];
          shreg_n = shreg >> 1;
          state_n = DATA;
        end
      end
      DATA: begin
        // shreg[0] is the parity bit once bcnt reaches 7
        if (fe) begin
          drv_n   = ~shreg[0];
          shreg_n = shreg >> 1;
          bcnt_n  = bcnt + 3'd1;
          if (bcnt == 3'd7)
            state_n = PARITY;
        end
      end
      PARITY: begin
        if (fe) begin
          drv_n   = 1'b0;
          state_n = STOP;
        end
      end
      STOP: begin
        if (fe) begin
`ifdef PS2_HOST_TX_ACK_CHECK_EN
          ack_n   = ~dat_s;
`endif
          state_n = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          state_n = IDLE;
          done_n  = 1'b1;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
          error_n = ~ack;
`else
          error_n = 1'b0;
`endif
        end
      end
      default: state_n = IDLE;
    endcase

    // Device-clock watchdog; an fe on the same cycle always wins.
    if (state_n != state) begin
      tcnt_n = '0;
    end else if (state != IDLE && state != INHIBIT) begin
      if (fe) begin
        tcnt_n = '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        tcnt_n  = '0;
        state_n = IDLE;
        drv_n   = 1'b0;
        done_n  = 1'b1;
        error_n = 1'b1;
      end else begin
        tcnt_n = tcnt + 1'b1;
      end
    end
  end

  assign ps2_clk_oe  = (state == INHIBIT);
  assign ps2_data_oe = drv;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pin model, PS/2 device model and
// a frame/parity model derived from the command byte.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TMO  = 200;
  localparam int HALF = 20;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] tx_byte;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clk_oe, data_oe, busy, done, error;
  logic       clk_pin, data_pin;

  assign clk_pin  = ~(clk_oe | dev_clk_low);
  assign data_pin = ~(data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tx_byte    (tx_byte),
    .ps2_clk    (clk_pin),
    .data       (data_pin),
    .ps2_clk_oe (clk_oe),
    .ps2_data_oe(data_oe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int n_done = 0;
  int n_inh = 0;
  bit last_err = 1'b0;
  int req_cyc = 0;
  int done_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Expected line frame: d0..d7, odd parity, stop=1.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0), b};
  endfunction

  // Per-cycle compare process.
  initial begin
    bit pb = 1'b0;
    bit pc = 1'b0;
    int run = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (busy || pb || done) begin
          if (!busy) chk("idle_oe", 32'({clk_oe, data_oe}), 0);
          if (done) chk("done_with_busy_fall", 32'({pb, busy}), 2);
          chk("error_only_with_done", 32'(error & ~done), 0);
        end
        if (done) begin
          n_done++;
          last_err = error;
          done_cyc = cyc;
        end
        if (clk_oe) begin
          run++;
        end else if (run != 0) begin
          chk("inhibit_len", run, INH);
          n_inh++;
          run = 0;
        end
        if (busy && !clk_oe && pc) req_cyc = cyc;
      end
      pb = busy;
      pc = clk_oe;
    end
  end

  task automatic dev_frame(input int nclk, input bit ack,
                           output logic [9:0] got);
    int w = 0;
    got = '0;
    while (!clk_oe && w < 400) begin @(negedge clk); w++; end
    while (clk_oe && w < 400) begin @(negedge clk); w++; end
    chk("host_release", 32'(w < 400), 1);
    if (w >= 400) return;
    chk("start_bit", 32'(data_pin), 0);
    repeat (10) @(negedge clk);
    for (int k = 1; k <= nclk; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k <= 10) got[k-1] = data_pin;
      dev_clk_low = 1'b0;
      if (k == 11) dev_data_low = 1'b0;
      if (k == 10 && ack) dev_data_low = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int n0, input int lim);
    int w = 0;
    while (n_done == n0 && w < lim) begin @(negedge clk); w++; end
    chk("done_seen", 32'(n_done != n0), 1);
  endtask

  task automatic pulse_start(input logic [7:0] b);
    @(negedge clk);
    tx_byte = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_xfer(input logic [7:0] b, input bit ack,
                          input bit exp_err, output logic [9:0] got);
    int n0 = n_done;
    pulse_start(b);
    dev_frame(11, ack, got);
    wait_done(n0, 400);
    chk("frame", 32'(got), 32'(frame_of(b)));
    chk("done_count", n_done - n0, 1);
    chk("error", 32'(last_err), 32'(exp_err));
  endtask

  initial begin
    logic [9:0] got;
    logic [9:0] m;
    int n0, i0;
    reset = 1'b1;
    start = 1'b0;
    tx_byte = '0;
    repeat (3) @(negedge clk);
    chk("reset_state",
        32'({clk_oe, data_oe, busy, done, error}), 0);
    reset = 1'b0;

    m = frame_of(8'hED);
    chk("model_parity_ED", 32'(m[8]), 1);
    m = frame_of(8'hF4);
    chk("model_parity_F4", 32'(m[8]), 0);

    // Set-LEDs: bits 1,0,1,1,0,1,1,1 then parity 1, stop 1.
    run_xfer(PS2_CMD_SET_LEDS, 1'b1, 1'b0, got);
    chk("ed_line_bits", 32'(got), 32'(10'b1_1_11101101));

    // Enable: parity 0, stop 1.
    run_xfer(PS2_CMD_ENABLE, 1'b1, 1'b0, got);
    chk("f4_line_bits", 32'(got), 32'(10'b1_0_11110100));

    // Device never clocks.
    repeat (5) @(negedge clk);
    n0 = n_done;
    pulse_start(8'h55);
    wait_done(n0, 600);
    chk("tmo_error", 32'(last_err), 1);
    chk("tmo_latency", done_cyc - req_cyc, TMO);
    chk("tmo_oe", 32'({clk_oe, data_oe}), 0);

    // Device withholds the ACK.
    repeat (5) @(negedge clk);
    run_xfer(8'hA5, 1'b0, ACK_CHK, got);

    // Reset in DATA after bit3.
    repeat (5) @(negedge clk);
    n0 = n_done;
    pulse_start(8'h0F);
    dev_frame(4, 1'b0, got);
    chk("partial_bits", 32'(got[3:0]), 32'hF);
    chk("busy_before_reset", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_xfer",
        32'({clk_oe, data_oe, busy, done}), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_done_on_reset", n_done - n0, 0);
    run_xfer(PS2_CMD_RESET, 1'b1, 1'b0, got);
    chk("ff_line_bits", 32'(got), 32'(10'b1_1_11111111));

    // Second start while busy is ignored.
    repeat (5) @(negedge clk);
    i0 = n_inh;
    n0 = n_done;
    fork
      run_xfer(PS2_CMD_SET_LEDS, 1'b1, 1'b0, got);
      begin
        repeat (200) @(negedge clk);
        tx_byte = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (100) @(negedge clk);
    chk("single_frame_inh", n_inh - i0, 1);
    chk("single_frame_done", n_done - n0, 1);
    chk("idle_after", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte from the ARM system to the keyboard, such as 8'hFF reset, 8'hED set-LEDs or 8'hF4 enable. It is the opposite direction of the keyboard receive path and shares the same ps2_clk/data pins through open-drain enables. It runs the full host request sequence: inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, device ACK. It reports completion and error to a memory-mapped register.

## Interface

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles the host holds ps2_clk low (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum clk cycles between device clock falling edges before abort (15 ms at 50 MHz).

Ports:
- clk, input, 1: system clock; all logic is on its rising edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: one-cycle request; sampled only in IDLE.
- tx_byte, input, 8: command byte; captured when start is accepted.
- ps2_clk, input, 1: raw PS/2 clock pin level (asynchronous).
- data, input, 1: raw PS/2 data pin level (asynchronous).
- ps2_clk_oe, output, 1: 1 drives the clock pin low; 0 releases it.
- ps2_data_oe, output, 1: 1 drives the data pin low; 0 releases it.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse at the end of a transfer.
- error, output, 1: valid only with done; 1 means timeout or missing ACK.

## Operation

- Reset: state IDLE; ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, error=0; shift register, bit counter and timers cleared. Reset mid-transfer releases both lines on the next clk edge and does not pulse done.
- Input conditioning: ps2_clk and data each pass through a 2-flop synchronizer. A falling-edge strobe (fe) is generated from the synchronized clock.
- IDLE: on start=1, capture tx_byte and compute odd parity (parity bit = ~^tx_byte), then go to INHIBIT. start while busy is ignored.
- INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES cycles. On the last cycle, set ps2_data_oe=1 (start bit = 0), then go to REQ.
- REQ: ps2_clk_oe=0 and ps2_data_oe stays 1. Wait for fe. On fe, present bit0 (ps2_data_oe = ~bit) and go to DATA.
- DATA: on each fe, present the next bit. After bit7 has been presented, the next fe presents parity and goes to PARITY.
- PARITY: on fe, set ps2_data_oe=0 (stop bit = 1) and go to STOP.
- STOP: on fe, sample synchronized data. ACK is data==0. Go to WAIT_IDLE.
- WAIT_IDLE: wait until synchronized ps2_clk=1 and data=1, then go to IDLE with done=1. error = (ACK missing).
- Timeout: a counter reloads on every fe and on state entry, and counts in REQ, DATA, PARITY, STOP and WAIT_IDLE. When it reaches TIMEOUT_CYCLES, release both lines, go to IDLE, and pulse done=1 with error=1.
- Simultaneous timeout and fe on the same cycle: fe wins and the counter reloads.

## Timing

- fe occurs 3 clk cycles after the pin's falling edge (2 synchronizer flops plus the edge register). ps2_data_oe updates on the cycle fe is high, which is well inside the device's clock-low half period.
- Transfer length is INHIBIT_CYCLES + 1, plus 11 device clocks, plus the WAIT_IDLE time.
- done and error are asserted for exactly 1 cycle, in the same cycle busy falls.
- start can be accepted on the cycle immediately after done.

## Configuration

- PS2_HOST_TX_ACK_CHECK_EN defined: the ACK is sampled in STOP and a missing ACK sets error.
- PS2_HOST_TX_ACK_CHECK_EN undefined: the STOP sample is ignored, and error reflects timeout only.
- Timing and states are identical in both cases.

## Structure

- Shared package ps2_pkg holds:
  - the state enum: IDLE, INHIBIT, REQ, DATA, PARITY, STOP, WAIT_IDLE;
  - command constants PS2_CMD_RESET=8'hFF, PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ENABLE=8'hF4.
- One sub-module, ps2_sync_edge: the 2-flop synchronizer plus the falling-edge detector. It is reusable by the keyboard receiver.

## Test plan

- Bench setup for all scenarios: INHIBIT_CYCLES=20, device model clocking at a 40-cycle period.
- tx_byte=8'hED -> ps2_clk_oe high for 20 cycles; data bits seen on the line are 1,0,1,1,0,1,1,1 with parity 1; device ACKs; done=1, error=0.
- tx_byte=8'hF4 -> parity bit 0 on the line, stop bit 1; done=1, error=0.
- Device never clocks, TIMEOUT_CYCLES=200 -> both oe outputs 0 and done=1, error=1 exactly 200 cycles after entering REQ.
- Device omits the ACK (data stays 1) -> done=1 with error=1 when PS2_HOST_TX_ACK_CHECK_EN is defined, error=0 when it is not.
- reset asserted during DATA after bit3 -> next cycle ps2_clk_oe=0, ps2_data_oe=0, busy=0, no done pulse. A following start with 8'hFF completes with parity 1.
- Second start pulse while busy -> ignored: only one 11-clock frame is sent, with the first tx_byte.
